selec_color_paleta: RTL and testbench

//  Parametrised on-screen colour selector; replaces the fixed two-colour selector.

---
 rtl/selec_color_paleta_pkg.sv | 24 ++
 rtl/selec_color_paleta_divisor_pulso.sv | 35 +++
 rtl/selec_color_paleta.sv | 146 ++++++++++++++
 tb/tb_selec_color_paleta.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/selec_color_paleta_pkg.sv
// Shared definitions for the palette colour selector:
// default palette entries, MANUAL/AUTO encoding and index wrap helper.
package selec_color_pkg;

    // Default palette entries at 8 bits per channel, {R,G,B}
    localparam logic [23:0] VERDE = 24'h00FF00;
    localparam logic [23:0] OLIVA = 24'h7F7F00;
    localparam logic [23:0] ROJO  = 24'hFF0000;
    localparam logic [23:0] AZUL  = 24'h0000FF;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } modo_e;

    // Next palette index, wrapping from n-1 back to 0
    function automatic int unsigned sig_indice(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/selec_color_paleta_divisor_pulso.sv
// Free-running 0..PERIODO-1 counter with synchronous clear.
// Ports: clk, rst_n, clr_i (sync clear), tick_o (1-cycle pulse at PERIODO-1).
module divisor_pulso #(
    parameter int PERIODO = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (PERIODO > 2) ? $clog2(PERIODO) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fin;

    assign fin    = (cnt_q == CNT_W'(PERIODO - 1));
    assign tick_o = fin && !clr_i;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || fin) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/selec_color_paleta.sv
// Palette colour selector: writable N_COLORES-entry RGB palette stepped by button or timer.
// Ports: clk, rst_n, boton, modo_auto, parpadeo, we_paleta/dir_paleta/dato_paleta, R/G/B, indice.
module selec_color_paleta
    import selec_color_pkg::*;
#(
    parameter  int COLOR_W   = 8,
    parameter  int N_COLORES = 4,
    parameter  int PERIODO   = 25_000_000,
    parameter  int PER_PARP  = 12_500_000,
    localparam int IDX_W     = $clog2(N_COLORES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   boton,
    input  logic                   modo_auto,
    input  logic                   parpadeo,
    input  logic                   we_paleta,
    input  logic [IDX_W-1:0]       dir_paleta,
    input  logic [3*COLOR_W-1:0]   dato_paleta,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B,
    output logic [IDX_W-1:0]       indice
);

    localparam int RGB_W = 3 * COLOR_W;

    // MSB-align an 8-bit channel value to COLOR_W bits
    function automatic logic [COLOR_W-1:0] escala(input logic [7:0] c);
        logic [COLOR_W+7:0] t;
        t = {c, {COLOR_W{1'b0}}};
        return t[COLOR_W+7 -: COLOR_W];
    endfunction

    function automatic logic [RGB_W-1:0] color_ini(input int unsigned i);
        logic [23:0] c;
        case (i)
            0:       c = VERDE;
            1:       c = OLIVA;
            2:       c = ROJO;
            3:       c = AZUL;
            default: c = '0;
        endcase
        return {escala(c[23:16]), escala(c[15:8]), escala(c[7:0])};
    endfunction

    logic [RGB_W-1:0] paleta_q [N_COLORES];
    logic [RGB_W-1:0] rgb_q, rgb_d, color_sel;
    logic [IDX_W-1:0] indice_q, indice_d;
    modo_e            estado_q, estado_d;
    logic             boton_q, flanco, avance;
    logic             clr_auto, tick_auto;
    logic             tick_parp, fase_q, fase_d, oculto;

    assign flanco = boton && !boton_q;

    // Counter runs only while staying in AUTO; any mode change restarts it
    assign clr_auto = (estado_d != estado_q) || (estado_q == MANUAL);

    divisor_pulso #(.PERIODO(PERIODO)) u_div_auto (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_auto),
        .tick_o (tick_auto)
    );

    divisor_pulso #(.PERIODO(PER_PARP)) u_div_parp (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!parpadeo),
        .tick_o (tick_parp)
    );

    always_comb begin
        estado_d = modo_auto ? AUTO : MANUAL;
        avance   = 1'b0;
        case (estado_q)
            MANUAL:  avance = flanco;
            AUTO:    avance = tick_auto;
            default: avance = 1'b0;
        endcase
        indice_d = indice_q;
        if (avance) begin
            indice_d = IDX_W'(sig_indice(int'(indice_q), N_COLORES));
        end
    end

    always_comb begin
        color_sel = '0;
        for (int i = 0; i < N_COLORES; i++) begin
            if (indice_q == IDX_W'(i)) begin
                color_sel = paleta_q[i];
            end
        end
    end

    // Raw parpadeo gates the overlay so dropping it shows colour on the next output
    assign oculto = parpadeo && fase_q;
    assign rgb_d  = oculto ? '0 : color_sel;

    always_comb begin
        fase_d = fase_q;
        if (!parpadeo) begin
            fase_d = 1'b0;
        end else if (tick_parp) begin
            fase_d = !fase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= MANUAL;
            indice_q <= '0;
            boton_q  <= 1'b0;
            fase_q   <= 1'b0;
            rgb_q    <= color_ini(0);
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
            boton_q  <= boton;
            fase_q   <= fase_d;
            rgb_q    <= rgb_d;
        end
    end

    // Register-based palette so reset can restore the default contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COLORES; i++) begin
                paleta_q[i] <= color_ini(i);
            end
        end else begin
            for (int i = 0; i < N_COLORES; i++) begin
                if (we_paleta && dir_paleta == IDX_W'(i)) begin
                    paleta_q[i] <= dato_paleta;
                end
            end
        end
    end

    assign R      = rgb_q[RGB_W-1 -: COLOR_W];
    assign G      = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign B      = rgb_q[COLOR_W-1:0];
    assign indice = indice_q;

endmodule

// File: tb/tb_selec_color_paleta.sv
// Scoreboard bench for selec_color_paleta (N_COLORES=5, PERIODO=4, PER_PARP=3).
// Random and directed stimulus against a cycle-level behavioural model.
module tb_selec_color_paleta;

    localparam int CW  = 8;
    localparam int N   = 5;
    localparam int IW  = $clog2(N);
    localparam int PER = 4;
    localparam int PP  = 3;

    logic          clk, rst_n;
    logic          boton, modo_auto, parpadeo, we_paleta;
    logic [IW-1:0] dir_paleta;
    logic [23:0]   dato_paleta;
    logic [CW-1:0] R, G, B;
    logic [IW-1:0] indice;

    selec_color_paleta #(
        .COLOR_W   (CW),
        .N_COLORES (N),
        .PERIODO   (PER),
        .PER_PARP  (PP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .boton       (boton),
        .modo_auto   (modo_auto),
        .parpadeo    (parpadeo),
        .we_paleta   (we_paleta),
        .dir_paleta  (dir_paleta),
        .dato_paleta (dato_paleta),
        .R           (R),
        .G           (G),
        .B           (B),
        .indice      (indice)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]   rgb;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [23:0] pal [N];
    int          m_idx, m_acnt, m_bcnt;
    bit          m_auto, m_prevb, m_hidden;

    function automatic void model_reset();
        pal[0] = 24'h00FF00;
        pal[1] = 24'h7F7F00;
        pal[2] = 24'hFF0000;
        pal[3] = 24'h0000FF;
        pal[4] = 24'h000000;
        m_idx = 0; m_acnt = 0; m_bcnt = 0;
        m_auto = 0; m_prevb = 0; m_hidden = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts what the DUT shows after the next edge
    task automatic step(input bit b, input bit ma, input bit par,
                        input bit we, input int dir, input logic [23:0] dat);
        exp_t e;
        bit   adv;
        @(negedge clk);
        boton = b; modo_auto = ma; parpadeo = par;
        we_paleta = we; dir_paleta = IW'(dir); dato_paleta = dat;
        e.rgb = (par && m_hidden) ? 24'h0 : pal[m_idx];
        adv = 0;
        if (m_auto && ma) begin
            if (m_acnt == PER - 1) begin
                adv = 1;
                m_acnt = 0;
            end else begin
                m_acnt++;
            end
        end else begin
            m_acnt = 0;
        end
        if (!m_auto && b && !m_prevb) adv = 1;
        m_prevb = b;
        m_auto = ma;
        if (we && dir < N) pal[dir] = dat;
        if (adv) m_idx = (m_idx + 1) % N;
        if (!par) begin
            m_bcnt = 0;
            m_hidden = 0;
        end else if (m_bcnt == PP - 1) begin
            m_bcnt = 0;
            m_hidden = !m_hidden;
        end else begin
            m_bcnt++;
        end
        e.idx = IW'(m_idx);
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit ma, input bit par);
        for (int i = 0; i < n; i++) step(0, ma, par, 0, 0, 24'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        boton = 0; modo_auto = 0; parpadeo = 0;
        we_paleta = 0; dir_paleta = '0; dato_paleta = '0;
        rst_n = 0;
        q.delete();
        model_reset();
        #1;
        chk("rst_R", 32'(R), 32'h00);
        chk("rst_G", 32'(G), 32'hFF);
        chk("rst_B", 32'(B), 32'h00);
        chk("rst_indice", 32'(indice), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("rgb", {8'h0, R, G, B}, {8'h0, e.rgb});
            chk("indice", 32'(indice), 32'(e.idx));
        end
    end

    initial begin
        int k, guard;
        rst_n = 1;
        boton = 0; modo_auto = 0; parpadeo = 0;
        we_paleta = 0; dir_paleta = '0; dato_paleta = '0;
        model_reset();
        #2;
        do_reset();
        idle(5, 0, 0);

        // Held button gives one advance, then four presses wrap through
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 24'h0);
        idle(2, 0, 0);
        for (int p = 0; p < 4; p++) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 24'h0);
            k = $urandom_range(1, 3);
            idle(k, 0, 0);
        end

        // AUTO with button noise, then a brief MANUAL detour
        for (int i = 0; i < 20; i++) step($urandom_range(0, 1), 1, 0, 0, 0, 24'h0);
        idle(2, 0, 0);
        for (int i = 0; i < 10; i++) step($urandom_range(0, 1), 1, 0, 0, 0, 24'h0);
        idle(2, 0, 0);

        // Overwrite the selected entry 1
        guard = 0;
        while (m_idx != 1 && guard < 2 * N) begin
            step(1, 0, 0, 0, 0, 24'h0);
            step(0, 0, 0, 0, 0, 24'h0);
            guard++;
        end
        step(0, 0, 0, 1, 1, 24'h123456);
        idle(2, 0, 0);
        for (int d = N; d < 8; d++) step(0, 0, 0, 1, d, $urandom);
        for (int i = 0; i < 2 * N; i++) begin
            step(1, 0, 0, 0, 0, 24'h0);
            step(0, 0, 0, 0, 0, 24'h0);
        end

        // Blink on, then off
        idle(20, 0, 1);
        idle(3, 0, 0);

        // Mixed random traffic
        begin
            bit ma, par;
            ma = 0; par = 0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) ma = !ma;
                if ($urandom_range(0, 15) == 0) par = !par;
                step($urandom_range(0, 1), ma, par,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom);
            end
        end

        // Reset in AUTO after a write must restore defaults
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, i % N, $urandom);
        do_reset();
        for (int i = 0; i < 2 * N; i++) begin
            step(1, 0, 0, 0, 0, 24'h0);
            step(0, 0, 0, 0, 0, 24'h0);
        end
        idle(2, 0, 0);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
